// File: rtl/rosc_counter.sv
// Ring-oscillator frequency counter: warms the oscillator up, counts its rising edges over a
// fixed clk window, then holds the result until the consumer accepts it.
module rosc_counter #(
    parameter int unsigned GATE_CYCLES   = 65536,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_WIDTH     = 24,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 osc_in,
    output logic                 osc_enable,
    input  logic                 start,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic                 valid,
    input  logic                 ready
);

    localparam int unsigned GateW   = $clog2(GATE_CYCLES + 1);
    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [GateW-1:0]   GateLast   = GateW'(GATE_CYCLES - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StGate,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SettleW-1:0]     settle_q;
    logic [GateW-1:0]       gate_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   overflow_q;
    logic                   osc_enable_q;
    logic                   busy_q;
    logic                   valid_q;

    logic edge_det;
    logic gate_entry;

    assign edge_det   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign gate_entry = (state_q == StSettle) && (settle_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (settle_q == '0) state_d = StGate;
            StGate:   if (gate_q == '0) state_d = StHold;
            StHold:   if (ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            settle_q     <= '0;
            gate_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            osc_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q  <= sync_q[SYNC_STAGES-1];

            // Outputs are registered from the next state so they line up with state_q.
            osc_enable_q <= (state_d != StIdle);
            busy_q       <= (state_d != StIdle);
            valid_q      <= (state_d == StHold);

            if (state_q == StIdle) begin
                settle_q <= SettleLast;
            end else if (state_q == StSettle && settle_q != '0) begin
                settle_q <= settle_q - SettleW'(1);
            end

            if (state_q == StSettle) begin
                gate_q <= GateLast;
            end else if (state_q == StGate && gate_q != '0) begin
                gate_q <= gate_q - GateW'(1);
            end

            if (gate_entry) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (state_q == StGate && edge_det) begin
                if (count_q == '1) begin
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign osc_enable = osc_enable_q;
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rosc_counter.sv
// Directed bench for rosc_counter: table of measurement vectors on a 1000-cycle gate instance
// plus hand sequences for reset mid-window, ignored start and saturation on a 4-bit instance.
module tb_rosc_counter;

    logic clk;
    logic reset;
    logic osc;
    logic start_a, ready_a, start_b, ready_b;
    logic osc_en_a, busy_a, overflow_a, valid_a;
    logic osc_en_b, busy_b, overflow_b, valid_b;
    logic [23:0] count_a;
    logic [3:0]  count_b;

    int checks = 0;
    int errors = 0;
    int half   = 0;

    rosc_counter #(
        .GATE_CYCLES  (1000),
        .SETTLE_CYCLES(16),
        .CNT_WIDTH    (24),
        .SYNC_STAGES  (2)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .osc_in    (osc),
        .osc_enable(osc_en_a),
        .start     (start_a),
        .busy      (busy_a),
        .count     (count_a),
        .overflow  (overflow_a),
        .valid     (valid_a),
        .ready     (ready_a)
    );

    rosc_counter #(
        .GATE_CYCLES  (200),
        .SETTLE_CYCLES(16),
        .CNT_WIDTH    (4),
        .SYNC_STAGES  (2)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .osc_in    (osc),
        .osc_enable(osc_en_b),
        .start     (start_b),
        .busy      (busy_b),
        .count     (count_b),
        .overflow  (overflow_b),
        .valid     (valid_b),
        .ready     (ready_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator: toggles every 'half' clk cycles, held low when half == 0.
    initial begin
        int cnt;
        cnt = 0;
        osc = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (half == 0) begin
                osc = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= half) begin
                    osc = ~osc;
                    cnt = 0;
                end
            end
        end
    end

    typedef struct {
        int half;
        int delay;
        int lo;
        int hi;
        bit poke;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] act, input int lo,
                               input int hi);
        checks++;
        if ($isunknown(act) || act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One measurement on dut_a; start accepted at P1, valid expected after P1017.
    task automatic run_a(input vec_t v);
        int bad;
        half    = v.half;
        ready_a = (v.delay == 0);
        @(posedge clk); #1 start_a = 1'b1;
        @(negedge clk);
        check("busy_before_start", busy_a, 0);
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk);
        check("busy_rise", busy_a, 1);
        check("osc_enable_rise", osc_en_a, 1);
        bad = 0;
        for (int c = 2; c <= 1016; c++) begin
            @(posedge clk); #1 start_a = v.poke && (c == 5 || c == 600);
            @(negedge clk);
            if (valid_a !== 1'b0 || busy_a !== 1'b1 || osc_en_a !== 1'b1) bad++;
        end
        check("measure_window", bad, 0);
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk);
        check("valid_latency", valid_a, 1);
        check_range("count", count_a, v.lo, v.hi);
        check("overflow", overflow_a, 0);
        bad = 0;
        for (int d = 0; d < v.delay; d++) begin
            @(posedge clk); #1;
            if (d == v.delay - 1) begin
                ready_a = 1'b1;
                start_a = v.poke;
            end
            @(negedge clk);
            if (valid_a !== 1'b1 || osc_en_a !== 1'b1) bad++;
            if ($isunknown(count_a) || count_a < v.lo || count_a > v.hi) bad++;
        end
        check("hold_stable", bad, 0);
        @(posedge clk); #1;
        start_a = 1'b0;
        ready_a = 1'b0;
        @(negedge clk);
        check("after_accept_valid", valid_a, 0);
        check("after_accept_osc_en", osc_en_a, 0);
        check("after_accept_busy", busy_a, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || valid_a !== 1'b0) bad++;
        end
        check("idle_after_accept", bad, 0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{half: 5,  delay: 0,  lo: 99,  hi: 101, poke: 1'b0};
        vecs[1] = '{half: 5,  delay: 50, lo: 99,  hi: 101, poke: 1'b0};
        vecs[2] = '{half: 2,  delay: 3,  lo: 249, hi: 251, poke: 1'b0};
        vecs[3] = '{half: 3,  delay: 0,  lo: 166, hi: 167, poke: 1'b0};
        vecs[4] = '{half: 0,  delay: 1,  lo: 0,   hi: 0,   poke: 1'b0};
        vecs[5] = '{half: 5,  delay: 2,  lo: 99,  hi: 101, poke: 1'b1};

        reset   = 1'b1;
        start_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        ready_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_osc_enable", osc_en_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_count", count_a, 0);
        check("rst_overflow", overflow_a, 0);
        check("rst_b_count", count_b, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Oscillator running while idle must not enable, validate or leak into the next count.
        half = 5;
        bad  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (valid_a !== 1'b0 || osc_en_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        check("idle_isolation", bad, 0);

        foreach (vecs[i]) run_a(vecs[i]);

        // Reset in gate cycle 500, with start and ready also high to test priority.
        half = 2;
        ready_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int c = 2; c <= 516; c++) @(posedge clk);
        #1;
        reset   = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        check("mid_gate_busy", busy_a, 1);
        check_range("mid_gate_count", count_a, 120, 130);
        @(posedge clk); #1;
        reset   = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_osc_en", osc_en_a, 0);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_count", count_a, 0);
        check("mid_rst_overflow", overflow_a, 0);
        @(negedge clk);
        check("mid_rst_no_queue", busy_a, 0);
        run_a(vecs[0]);

        // Saturation on the 4-bit instance: 50 edges in a 200-cycle gate.
        half = 2;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int c = 2; c <= 216; c++) @(posedge clk);
        @(negedge clk);
        check("sat_valid_early", valid_b, 0);
        @(posedge clk);
        @(negedge clk);
        check("sat_valid", valid_b, 1);
        check("sat_count", count_b, 15);
        check("sat_overflow", overflow_b, 1);
        @(posedge clk); #1 ready_b = 1'b1;
        @(posedge clk); #1 ready_b = 1'b0;
        @(negedge clk);
        check("sat_accept_valid", valid_b, 0);
        check("sat_overflow_sticky", overflow_b, 1);

        half = 0;
        repeat (5) @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int c = 2; c <= 16; c++) @(posedge clk);
        @(negedge clk);
        check("settle_overflow_kept", overflow_b, 1);
        @(posedge clk);
        @(negedge clk);
        check("gate_entry_count", count_b, 0);
        check("gate_entry_overflow", overflow_b, 0);
        for (int c = 18; c <= 217; c++) @(posedge clk);
        @(negedge clk);
        check("quiet_valid", valid_b, 1);
        check("quiet_count", count_b, 0);
        check("quiet_overflow", overflow_b, 0);
        @(posedge clk); #1 ready_b = 1'b1;
        @(posedge clk); #1 ready_b = 1'b0;
        @(negedge clk);
        check("quiet_accept_busy", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
